// File: rtl/mem_port_arbiter.sv
// Arbiter that shares one single-ported memory between instruction fetch and
// data access. One transaction can be outstanding at a time. Data has priority
// over fetch, and a streak limiter keeps fetch from being starved.
module mem_port_arbiter #(
   parameter int unsigned ADDR_W       = 32,
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic                if_gnt,
   output logic                if_rvalid,
   output logic [DATA_W-1:0]   if_rdata,
   input  logic                d_req,
   input  logic                d_we,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   input  logic [DATA_W/8-1:0] d_wstrb,
   output logic                d_gnt,
   output logic                d_rvalid,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                mem_req,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wstrb,
   input  logic                mem_ack,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                busy
);

   localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

   typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

   state_t              state_q, state_d;
   logic [SW-1:0]       streak_q, streak_d;
   logic                own_we_q, own_we_d;
   logic [DATA_W-1:0]   if_rdata_q, d_rdata_q;
   logic                slot, pick_i, pick_d;

   // State, streak, owner write flag and held read data.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         streak_q   <= '0;
         own_we_q   <= 1'b0;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
      end else begin
         state_q    <= state_d;
         streak_q   <= streak_d;
         own_we_q   <= own_we_d;
         if_rdata_q <= if_rdata;
         d_rdata_q  <= d_rdata;
      end
   end

   // Arbitration, memory command, response routing and next state.
   always_comb begin
      state_d   = state_q;
      streak_d  = streak_q;
      own_we_d  = own_we_q;
      if_gnt    = 1'b0;
      d_gnt     = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_wstrb = '0;
      busy      = (state_q != IDLE);

      if_rvalid = (state_q == BUSY_I) && mem_ack;
      d_rvalid  = (state_q == BUSY_D) && mem_ack;
      if_rdata  = if_rvalid ? mem_rdata : if_rdata_q;
      if (d_rvalid) d_rdata = own_we_q ? '0 : mem_rdata;
      else          d_rdata = d_rdata_q;

      // The reset term keeps the grant path quiet while reset is asserted,
      // since the state register alone would present an open IDLE slot.
      slot   = reset && ((state_q == IDLE) || mem_ack);
      pick_i = if_req && (!d_req || (streak_q == LIMIT));
      pick_d = d_req && !pick_i;

      if (slot) begin
         state_d = IDLE;
         if (pick_d) begin
            d_gnt     = 1'b1;
            mem_req   = 1'b1;
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            mem_wstrb = d_wstrb;
            own_we_d  = d_we;
            state_d   = BUSY_D;
            if (!if_req)                streak_d = '0;
            else if (streak_q != LIMIT) streak_d = streak_q + SW'(1);
         end else if (pick_i) begin
            if_gnt   = 1'b1;
            mem_req  = 1'b1;
            mem_addr = if_addr;
            own_we_d = 1'b0;
            state_d  = BUSY_I;
            streak_d = '0;
         end
      end
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the instruction-fetch stage and the data-memory stage of the 5-stage pipeline.
- Allows one outstanding transaction at a time.
- Data accesses have fixed priority over fetches. A starvation limiter keeps fetch from being locked out.
- Responses are routed back to the owning requester. Downstream of the arbiter the memory uses a req/ack handshake with variable latency.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports.
- STARVE_LIMIT, 4, consecutive data grants (while fetch is waiting) after which fetch wins the next contended arbitration. Must be ≥ 1.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- if_req  in  1  fetch request; held high with if_addr stable until if_gnt
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  one-cycle pulse: fetch request accepted
- if_rvalid  out  1  one-cycle pulse: if_rdata valid
- if_rdata  out  DATA_W  fetch read data
- d_req  in  1  data request; held high with d_we/d_addr/d_wdata/d_wstrb stable until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_wstrb  in  DATA_W/8  byte enables for stores
- d_gnt  out  1  one-cycle pulse: data request accepted
- d_rvalid  out  1  one-cycle pulse: load data valid, or store complete
- d_rdata  out  DATA_W  load data
- mem_req  out  1  memory command valid; one-cycle pulse per transaction
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_wstrb  out  DATA_W/8  memory byte enables
- mem_ack  in  1  memory response/completion; ≥1 cycle after mem_req
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack
- busy  out  1  a transaction is outstanding

Behaviour:
- Clock and reset: clock clk; reset reset, asynchronous, active-low.
- State register: IDLE, BUSY_I, BUSY_D.
- Reset values (async, immediate): state IDLE, streak counter 0, busy 0.
  - All grant, valid and mem_req outputs are 0.
  - mem_we = 0; mem_addr, mem_wdata, mem_wstrb = 0.
  - if_rdata and d_rdata = 0, with rvalid low.
- Arbitration slot: exists in a cycle when state == IDLE, or when state is BUSY_x and mem_ack == 1 (back-to-back issue).
- Winner selection:
  - If d_req only: data wins.
  - If if_req only: fetch wins.
  - If both and streak == STARVE_LIMIT: fetch wins.
  - If both otherwise: data wins.
- Grant is combinational in the slot cycle: the winner's gnt = 1 and mem_req = 1 in the same cycle.
  - mem_we, mem_addr, mem_wdata and mem_wstrb are driven from the winner's inputs.
  - For a fetch: mem_we = 0, mem_wstrb = 0, mem_wdata = 0.
- Next state: BUSY_I or BUSY_D according to the winner. If no request in the slot, next state is IDLE.
- Memory outputs when mem_req = 0: mem_we, mem_addr, mem_wdata, mem_wstrb driven to 0.
- Response routing:
  - In BUSY_I with mem_ack: if_rvalid = 1 and if_rdata = mem_rdata.
  - In BUSY_D with mem_ack: d_rvalid = 1. d_rdata = mem_rdata for loads; d_rdata = 0 for stores (we of the owner is latched at grant).
- rdata hold: rdata outputs hold their last value when rvalid = 0.
- mem_ack in IDLE: ignored. No rvalid, no state change; the slot still arbitrates normally.
- busy = (state != IDLE).
- Minimum throughput: one transaction per cycle when memory acks on the next cycle. Minimum latency is gnt to rvalid = 1 cycle.
- Streak counter (width clog2(STARVE_LIMIT+1)), updated on each grant:
  - Fetch grant: streak cleared to 0.
  - Data grant with if_req = 1: streak incremented, saturating at STARVE_LIMIT.
  - Data grant with if_req = 0: streak cleared to 0.
- Requester protocol violations are not checked: a req dropped before gnt simply removes that requester from the next slot.
- Reset mid-transaction: the transaction is abandoned and no rvalid is produced. A late mem_ack after reset release lands in IDLE and is ignored.
- Requests arriving while busy without an ack wait; gnt stays 0.

Test Plan:
- Reset check: assert reset low mid-BUSY_D → all outputs 0 immediately. After release, inject mem_ack=1 → no if_rvalid/d_rvalid, state IDLE, busy=0.
- Single fetch, 3-cycle memory: if_req=1, if_addr=0x100, mem acks 3 cycles later with rdata=0x00500093 → expected:
  - grant cycle: if_gnt=1, mem_req=1, mem_addr=0x100, mem_we=0.
  - 3 cycles later: if_rvalid=1, if_rdata=0x00500093.
  - busy high for 3 cycles.
- Simultaneous requests: if_req=1 (0x104), d_req=1 store 0x2000/0xDEADBEEF/wstrb 0xF → expected:
  - first: d_gnt=1, mem_we=1, mem_wdata=0xDEADBEEF.
  - on its ack: d_rvalid=1, d_rdata=0, and if_gnt=1 in the same cycle with mem_addr=0x104.
- Back-to-back loads, 1-cycle memory: d_req held with loads to 0x2000, 0x2004, 0x2008 → one d_gnt per cycle; d_rvalid in each following cycle with matching mem_rdata.
- Starvation, STARVE_LIMIT=4: d_req and if_req held high continuously, 1-cycle memory → grant sequence D,D,D,D,I,D,D,D,D,I…; streak returns to 0 after each fetch grant.
- Stray ack and withdrawn request:
  - mem_ack=1 in IDLE with no requests → no rvalid, mem_req=0.
  - if_req pulsed while BUSY_D then dropped before ack → no if_gnt, no fetch issued.
